// File: rtl/b2g_converter.sv
// Binary <-> Gray code converter: zero-latency binary->Gray view of din plus a
// one-cycle registered result whose direction is chosen per sample by mode.
module b2g_converter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] gray_comb,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             out_mode
);

    logic [WIDTH-1:0] b2g_w;
    logic [WIDTH-1:0] g2b_w;
    logic [WIDTH-1:0] dout_d;
    logic [WIDTH-1:0] dout_q;
    logic             out_valid_q;
    logic             out_mode_q;

    assign b2g_w = din ^ (din >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it; written as a
    // reduction per bit so there is no combinational chain through one vector.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_g2b
            assign g2b_w[gi] = ^din[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        dout_d = b2g_w;
        if (mode) begin
            dout_d = g2b_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            // Data and mode only move on accepted samples so idle din/mode never leak out.
            if (in_valid) begin
                dout_q     <= dout_d;
                out_mode_q <= mode;
            end
        end
    end

    assign gray_comb = b2g_w;
    assign dout      = dout_q;
    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_b2g_converter.sv
// Bench for b2g_converter: WIDTH=4 table vectors, sweep and reset/idle
// sequences through a scoreboard, plus WIDTH=8 and WIDTH=1 instances.
module tb_b2g_converter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] gray_comb, dout;
    logic       out_valid, out_mode;

    logic       in_valid8 = 1'b0;
    logic       mode8 = 1'b0;
    logic [7:0] din8 = '0;
    logic [7:0] gray_comb8, dout8;
    logic       out_valid8, out_mode8;

    logic       in_valid1 = 1'b0;
    logic       mode1 = 1'b0;
    logic [0:0] din1 = '0;
    logic [0:0] gray_comb1, dout1;
    logic       out_valid1, out_mode1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    b2g_converter #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode), .din(din),
        .gray_comb(gray_comb), .dout(dout), .out_valid(out_valid), .out_mode(out_mode)
    );

    b2g_converter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .mode(mode8), .din(din8),
        .gray_comb(gray_comb8), .dout(dout8), .out_valid(out_valid8), .out_mode(out_mode8)
    );

    b2g_converter #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .mode(mode1), .din(din1),
        .gray_comb(gray_comb1), .dout(dout1), .out_valid(out_valid1), .out_mode(out_mode1)
    );

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       m;
    } exp_t;

    typedef struct {
        logic [3:0] din;
        logic       mode;
        logic [3:0] gray;
        logic [3:0] dout;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[10];
    logic [3:0] m_dout = '0;
    logic       m_mode = 1'b0;
    logic [3:0] g_cap[16];

    function automatic logic [3:0] b2g_f(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle on the WIDTH=4 instance, push the expected registered
    // result, then pop and compare it one edge later.
    task automatic cycle(input logic v, input logic m, input logic [3:0] d,
                         input logic [3:0] exp_gray, input logic [3:0] exp_dout);
        exp_t e;
        in_valid = v;
        mode     = m;
        din      = d;
        #1;
        check("gray_comb", {4'h0, gray_comb}, {4'h0, exp_gray});
        if (v) begin
            m_dout = exp_dout;
            m_mode = m;
        end
        sb.push_back('{v: v, d: m_dout, m: m_mode});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_valid", {7'h0, out_valid}, {7'h0, e.v});
        check("dout", {4'h0, dout}, {4'h0, e.d});
        check("out_mode", {7'h0, out_mode}, {7'h0, e.m});
        $display("txn v=%0b m=%0b din=%b -> gray_comb=%b dout=%b out_valid=%0b out_mode=%0b",
                 v, m, d, gray_comb, dout, out_valid, out_mode);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{4'b1011, 1'b0, 4'b1110, 4'b1110};
        vecs[1] = '{4'b0111, 1'b0, 4'b0100, 4'b0100};
        vecs[2] = '{4'b0101, 1'b0, 4'b0111, 4'b0111};
        vecs[3] = '{4'b1100, 1'b0, 4'b1010, 4'b1010};
        vecs[4] = '{4'b1111, 1'b0, 4'b1000, 4'b1000};
        vecs[5] = '{4'b1110, 1'b1, 4'b1001, 4'b1011};
        vecs[6] = '{4'b0100, 1'b1, 4'b0110, 4'b0111};
        vecs[7] = '{4'b0111, 1'b1, 4'b0100, 4'b0101};
        vecs[8] = '{4'b1010, 1'b1, 4'b1111, 4'b1100};
        vecs[9] = '{4'b1000, 1'b1, 4'b1100, 4'b1111};

        // Reset state before any clock edge
        #2;
        check("rst_dout", {4'h0, dout}, 8'h00);
        check("rst_out_valid", {7'h0, out_valid}, 8'h00);
        check("rst_out_mode", {7'h0, out_mode}, 8'h00);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, back-to-back
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, vecs[i].mode, vecs[i].din, vecs[i].gray, vecs[i].dout);
        end

        // Exhaustive mode=0 sweep with single-bit-step property, then round trip
        for (int x = 0; x < 16; x++) begin
            cycle(1'b1, 1'b0, 4'(x), b2g_f(4'(x)), b2g_f(4'(x)));
            g_cap[x] = dout;
            if (x > 0) begin
                check("gray_step", 8'($countones(g_cap[x] ^ g_cap[x-1])), 8'd1);
            end
        end
        check("gray_wrap", 8'($countones(g_cap[15] ^ g_cap[0])), 8'd1);
        for (int x = 0; x < 16; x++) begin
            cycle(1'b1, 1'b1, g_cap[x], b2g_f(g_cap[x]), 4'(x));
        end

        // Valid pulse pattern 1,0,0,1 with din toggling while idle
        cycle(1'b1, 1'b0, 4'b0110, 4'b0101, 4'b0101);
        cycle(1'b0, 1'b1, 4'b1001, 4'b1101, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0011, 4'b0010, 4'b0000);
        cycle(1'b1, 1'b1, 4'b0011, 4'b0010, 4'b0010);

        // Asynchronous reset between edges with a sample pending
        cycle(1'b1, 1'b1, 4'b1010, 4'b1111, 4'b1100);
        in_valid = 1'b1;
        mode     = 1'b0;
        din      = 4'b0111;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dout", {4'h0, dout}, 8'h00);
        check("midrst_out_valid", {7'h0, out_valid}, 8'h00);
        check("midrst_out_mode", {7'h0, out_mode}, 8'h00);
        check("midrst_gray_comb", {4'h0, gray_comb}, 8'h04);
        @(posedge clk);
        #1;
        check("inrst_dout", {4'h0, dout}, 8'h00);
        check("inrst_out_valid", {7'h0, out_valid}, 8'h00);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        m_dout   = '0;
        m_mode   = 1'b0;
        cycle(1'b0, 1'b1, 4'b1111, 4'b1000, 4'b0000);
        cycle(1'b0, 1'b0, 4'b0101, 4'b0111, 4'b0000);
        cycle(1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0001);

        // WIDTH=8 and WIDTH=1 instances
        in_valid8 = 1'b1; mode8 = 1'b0; din8 = 8'hFF;
        in_valid1 = 1'b1; mode1 = 1'b0; din1 = 1'b1;
        #1;
        check("w8_gray_comb", gray_comb8, 8'h80);
        check("w1_gray_comb", {7'h0, gray_comb1}, 8'h01);
        @(posedge clk);
        #1;
        check("w8_b2g_dout", dout8, 8'h80);
        check("w8_out_valid", {7'h0, out_valid8}, 8'h01);
        check("w1_b2g_dout", {7'h0, dout1}, 8'h01);
        $display("txn w8 din=FF m=0 -> dout=%h; w1 din=1 m=0 -> dout=%b", dout8, dout1);
        mode8 = 1'b1; din8 = 8'h80;
        mode1 = 1'b1; din1 = 1'b1;
        @(posedge clk);
        #1;
        check("w8_g2b_dout", dout8, 8'hFF);
        check("w8_out_mode", {7'h0, out_mode8}, 8'h01);
        check("w1_g2b_dout", {7'h0, dout1}, 8'h01);
        $display("txn w8 din=80 m=1 -> dout=%h; w1 din=1 m=1 -> dout=%b", dout8, dout1);
        mode1 = 1'b0; din1 = 1'b0; in_valid8 = 1'b0;
        @(posedge clk);
        #1;
        check("w1_zero_dout", {7'h0, dout1}, 8'h00);
        check("w8_hold_dout", dout8, 8'hFF);
        check("w8_idle_valid", {7'h0, out_valid8}, 8'h00);
        $display("txn w1 din=0 m=0 -> dout=%b; w8 idle dout=%h", dout1, dout8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
